// File: rtl/pc_sequencer_if.sv
// Fetch-stage bundle between the hazard/branch logic, instruction memory and the PC sequencer.
// master = hazard/branch side driving redirects, slave = the sequencer owning the PC.
interface pc_sequencer_if #(
  parameter int SIZE = 32
) ();
  logic            stall;
  logic            branch_taken;
  logic [SIZE-1:0] branch_target;
  logic            jump;
  logic [SIZE-1:0] jump_target;
  logic            exception;
  logic            imem_ready;
  logic [SIZE-1:0] pc;
  logic [SIZE-1:0] pc_plus4;
  logic            fetch_valid;
  logic            flush;
  logic            misalign;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, exception, imem_ready,
    input  pc, pc_plus4, fetch_valid, flush, misalign
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, exception, imem_ready,
    output pc, pc_plus4, fetch_valid, flush, misalign
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the MIPS fetch stage: PC+4, redirects, exception vectoring, waits.
// Optional build macro PC_ALIGN_CHECK_EN traps misaligned jump/branch targets to EXC_VECTOR.
module pc_sequencer #(
  parameter int              SIZE         = 32,
  parameter logic [SIZE-1:0] RESET_VECTOR = '0,
  parameter logic [SIZE-1:0] EXC_VECTOR   = SIZE'(32'h80)
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [SIZE-1:0] pc_r, pc_s;
  logic            pend_valid_r, pend_valid_s;
  logic [SIZE-1:0] pend_target_r, pend_target_s;
  logic [SIZE-1:0] target_s;
  logic            bad_align_s;
  logic            redirect_jb_s;
  logic            fetch_valid_s;
  logic            flush_s;
  logic            misalign_s;

  assign redirect_jb_s = bus.jump | bus.branch_taken;

  // Jump beats branch; a misaligned target is swapped for the exception vector when checking is built in.
  always_comb begin
    bad_align_s = 1'b0;
    if (bus.jump) begin
      target_s = bus.jump_target;
    end else begin
      target_s = bus.branch_target;
    end
`ifdef PC_ALIGN_CHECK_EN
    if (redirect_jb_s && (target_s[1:0] != 2'b00)) begin
      bad_align_s = 1'b1;
      target_s    = EXC_VECTOR;
    end else begin
      bad_align_s = 1'b0;
    end
`endif
  end

  // Next PC, pending redirect, state and the combinational fetch/flush outputs.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    pend_valid_s  = pend_valid_r;
    pend_target_s = pend_target_r;
    flush_s       = 1'b0;
    misalign_s    = 1'b0;

    case (state_r)
      BOOT:    state_s = RUN;
      RUN:     state_s = bus.imem_ready ? RUN : WAIT;
      WAIT:    state_s = bus.imem_ready ? RUN : WAIT;
      default: state_s = BOOT;
    endcase

    if (bus.exception) begin
      pc_s         = EXC_VECTOR;
      state_s      = RUN;
      pend_valid_s = 1'b0;
      flush_s      = 1'b1;
    end else if (redirect_jb_s) begin
      flush_s    = 1'b1;
      misalign_s = bad_align_s;
      if (bus.imem_ready || (state_r == BOOT)) begin
        pc_s         = target_s;
        pend_valid_s = 1'b0;
      end else begin
        // Memory still busy with the old address: park the target until it answers.
        pend_valid_s  = 1'b1;
        pend_target_s = target_s;
      end
    end else if (pend_valid_r && bus.imem_ready) begin
      pc_s         = pend_target_r;
      pend_valid_s = 1'b0;
    end else if ((state_r != BOOT) && bus.imem_ready && !bus.stall) begin
      pc_s = pc_r + SIZE'(32'd4);
    end else begin
      pc_s = pc_r;
    end

    // The word returned while a parked redirect retires is wrong-path, so it is never captured.
    fetch_valid_s = ((state_r == RUN) || (state_r == WAIT)) && bus.imem_ready && !bus.stall &&
                    !bus.exception && !redirect_jb_s && !pend_valid_r;
  end

  // State, PC and pending-redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= BOOT;
      pc_r          <= RESET_VECTOR;
      pend_valid_r  <= 1'b0;
      pend_target_r <= '0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      pend_valid_r  <= pend_valid_s;
      pend_target_r <= pend_target_s;
    end
  end

  assign bus.pc          = pc_r;
  assign bus.pc_plus4    = pc_r + SIZE'(32'd4);
  assign bus.fetch_valid = fetch_valid_s;
  assign bus.flush       = flush_s;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.misalign    = misalign_s;
`else
  assign bus.misalign    = 1'b0;
`endif

endmodule
